// File: rtl/issue_ctrl.sv
// issue_ctrl: decode-to-execute issue control.
//   Decides per cycle whether the decoded instruction issues, stalls or is
//   flushed. Tracks in-flight register writes in a 1-bit-per-register
//   scoreboard. Serialises control transfers and sequences ecall (trap pulse),
//   ebreak (drain then halt) and decode-error lockup.
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   id_valid_i, rd/rs1/rs2_enable_i   decode slot valid and operand usage
//   rd_i, rs1_i, rs2_i                register indices
//   ctrl_xfer_i                       branch / jal / jalr
//   env_interrupt_i                   bit0 ecall, bit1 ebreak
//   decode_error_i                    illegal opcode
//   ex_resolve_i, ex_redirect_i       control transfer resolution from EX
//   wb_valid_i, wb_rd_i               writeback retirement
//   issue_o, stall_o, flush_o         pipeline control (combinational)
//   trap_o, halted_o, error_o         environment status (combinational)
// Optional feature macro: PERF_CNT_EN adds perf_issued_o / perf_stall_o.
module issue_ctrl #(
  parameter int unsigned RF_SIZE   = 5,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               id_valid_i,
  input  logic               rd_enable_i,
  input  logic               rs1_enable_i,
  input  logic               rs2_enable_i,
  input  logic [RF_SIZE-1:0] rd_i,
  input  logic [RF_SIZE-1:0] rs1_i,
  input  logic [RF_SIZE-1:0] rs2_i,
  input  logic               ctrl_xfer_i,
  input  logic [1:0]         env_interrupt_i,
  input  logic               decode_error_i,
  input  logic               ex_resolve_i,
  input  logic               ex_redirect_i,
  input  logic               wb_valid_i,
  input  logic [RF_SIZE-1:0] wb_rd_i,
  output logic               issue_o,
  output logic               stall_o,
  output logic               flush_o,
  output logic               trap_o,
  output logic               halted_o,
  output logic               error_o
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] perf_issued_o,
  output logic [CNT_WIDTH-1:0] perf_stall_o
`endif
);

  localparam int unsigned NREG = 2 ** RF_SIZE;

  localparam logic [2:0] S_RUN       = 3'd0;
  localparam logic [2:0] S_WAIT_CTRL = 3'd1;
  localparam logic [2:0] S_DRAIN     = 3'd2;
  localparam logic [2:0] S_HALT      = 3'd3;
  localparam logic [2:0] S_ERR       = 3'd4;

  logic [2:0]      r_state;
  logic [2:0]      w_next_state;
  logic [NREG-1:0] r_sb;
  logic [NREG-1:0] w_clr;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_sb_eff;
  logic            w_hazard;

  // Same-cycle writeback clears the pending bit before the hazard check
  assign w_clr    = wb_valid_i ? (NREG'(1) << wb_rd_i) : '0;
  assign w_sb_eff = r_sb & ~w_clr;

  // Index 0 is never pending regardless of scoreboard contents
  assign w_hazard = (rs1_enable_i && (rs1_i != '0) && w_sb_eff[rs1_i]) ||
                    (rs2_enable_i && (rs2_i != '0) && w_sb_eff[rs2_i]) ||
                    (rd_enable_i  && (rd_i  != '0) && w_sb_eff[rd_i]);

  assign w_set = (issue_o && rd_enable_i && (rd_i != '0)) ? (NREG'(1) << rd_i) : '0;

  // Next-state and output decode
  always_comb begin
    w_next_state = r_state;
    issue_o      = 1'b0;
    stall_o      = 1'b0;
    flush_o      = 1'b0;
    trap_o       = 1'b0;
    halted_o     = 1'b0;
    error_o      = 1'b0;
    if (!rst_i) begin
      case (r_state)
        S_RUN: begin
          if (id_valid_i) begin
            if (decode_error_i) begin
              stall_o      = 1'b1;
              w_next_state = S_ERR;
            end else if (env_interrupt_i[1]) begin
              stall_o      = 1'b1;
              w_next_state = S_DRAIN;
            end else if (w_hazard) begin
              stall_o = 1'b1;
            end else begin
              issue_o = 1'b1;
              // ecall outranks ctrl_xfer: it issues with the trap pulse only
              if (env_interrupt_i[0]) begin
                trap_o = 1'b1;
              end else if (ctrl_xfer_i) begin
                w_next_state = S_WAIT_CTRL;
              end
            end
          end
        end
        S_WAIT_CTRL: begin
          // Decode slot is not evaluated in the resolve cycle
          if (ex_resolve_i) begin
            flush_o      = ex_redirect_i;
            w_next_state = S_RUN;
          end else begin
            stall_o = 1'b1;
          end
        end
        S_DRAIN: begin
          stall_o = 1'b1;
          if (w_sb_eff == '0) begin
            w_next_state = S_HALT;
          end
        end
        S_HALT: begin
          halted_o = 1'b1;
          stall_o  = 1'b1;
        end
        S_ERR: begin
          error_o = 1'b1;
          stall_o = 1'b1;
          flush_o = 1'b1;
        end
        default: w_next_state = S_RUN;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Scoreboard: set on issue wins over a same-index writeback clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sb <= '0;
    end else begin
      r_sb <= (r_sb & ~w_clr) | w_set;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_WIDTH-1:0] r_perf_issued;
  logic [CNT_WIDTH-1:0] r_perf_stall;

  // Performance counters, wrap naturally
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_perf_issued <= '0;
      r_perf_stall  <= '0;
    end else begin
      if (issue_o) begin
        r_perf_issued <= r_perf_issued + CNT_WIDTH'(1);
      end
      if (stall_o && !halted_o && !error_o) begin
        r_perf_stall <= r_perf_stall + CNT_WIDTH'(1);
      end
    end
  end

  assign perf_issued_o = r_perf_issued;
  assign perf_stall_o  = r_perf_stall;
`else
  logic w_unused_cnt_width;
  assign w_unused_cnt_width = ^CNT_WIDTH;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: table of per-cycle vectors plus a
// hand-written long control-transfer wait.
module tb_issue_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       id_valid_i, rd_enable_i, rs1_enable_i, rs2_enable_i;
  logic [4:0] rd_i, rs1_i, rs2_i;
  logic       ctrl_xfer_i;
  logic [1:0] env_interrupt_i;
  logic       decode_error_i, ex_resolve_i, ex_redirect_i, wb_valid_i;
  logic [4:0] wb_rd_i;
  logic       issue_o, stall_o, flush_o, trap_o, halted_o, error_o;

  issue_ctrl dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .id_valid_i      (id_valid_i),
    .rd_enable_i     (rd_enable_i),
    .rs1_enable_i    (rs1_enable_i),
    .rs2_enable_i    (rs2_enable_i),
    .rd_i            (rd_i),
    .rs1_i           (rs1_i),
    .rs2_i           (rs2_i),
    .ctrl_xfer_i     (ctrl_xfer_i),
    .env_interrupt_i (env_interrupt_i),
    .decode_error_i  (decode_error_i),
    .ex_resolve_i    (ex_resolve_i),
    .ex_redirect_i   (ex_redirect_i),
    .wb_valid_i      (wb_valid_i),
    .wb_rd_i         (wb_rd_i),
    .issue_o         (issue_o),
    .stall_o         (stall_o),
    .flush_o         (flush_o),
    .trap_o          (trap_o),
    .halted_o        (halted_o),
    .error_o         (error_o)
  );

  always #5 clk_i = ~clk_i;

  // exp/mask bit order: {issue, stall, flush, trap, halted, error}
  typedef struct {
    string      name;
    logic       rst;
    logic       idv;
    logic [2:0] en;    // {rd, rs1, rs2} enables
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [3:0] ctl;   // {decode_error, ctrl_xfer, ebreak, ecall}
    logic [1:0] ex;    // {resolve, redirect}
    logic       wbv;
    logic [4:0] wbrd;
    logic [5:0] exp;
    logic [5:0] mask;
  } vec_t;

  localparam logic [5:0] M  = 6'b111111;
  localparam logic [5:0] MI = 6'b100000;

  vec_t vq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic add(input string n, input logic r, input logic v, input logic [2:0] en,
                     input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2,
                     input logic [3:0] ctl, input logic [1:0] ex, input logic wbv,
                     input logic [4:0] wbrd, input logic [5:0] exp, input logic [5:0] mask);
    vec_t t;
    t.name = n; t.rst = r; t.idv = v; t.en = en; t.rd = rd; t.rs1 = s1; t.rs2 = s2;
    t.ctl = ctl; t.ex = ex; t.wbv = wbv; t.wbrd = wbrd; t.exp = exp; t.mask = mask;
    vq.push_back(t);
  endtask

  task automatic apply(input vec_t t);
    rst_i           = t.rst;
    id_valid_i      = t.idv;
    rd_enable_i     = t.en[2];
    rs1_enable_i    = t.en[1];
    rs2_enable_i    = t.en[0];
    rd_i            = t.rd;
    rs1_i           = t.rs1;
    rs2_i           = t.rs2;
    decode_error_i  = t.ctl[3];
    ctrl_xfer_i     = t.ctl[2];
    env_interrupt_i = t.ctl[1:0];
    ex_resolve_i    = t.ex[1];
    ex_redirect_i   = t.ex[0];
    wb_valid_i      = t.wbv;
    wb_rd_i         = t.wbrd;
  endtask

  // Apply one vector, compare mid-cycle, then advance past the next edge
  task automatic run_vec(input vec_t t);
    logic [5:0] got;
    apply(t);
    @(negedge clk_i);
    got = {issue_o, stall_o, flush_o, trap_o, halted_o, error_o};
    n_vec++;
    if ((got & t.mask) !== (t.exp & t.mask)) begin
      n_err++;
      $display("FAIL %s: got {iss,stl,fls,trp,hlt,err}=%b expected %b (mask %b)",
               t.name, got, t.exp, t.mask);
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    vec_t h;
    // name          rst v  en     rd s1 s2 ctl      ex    wbv wbrd exp        mask
    add("reset",      1, 1, 3'b111, 1, 2, 3, 4'b0100, 2'b11, 0, 0, 6'b000000, M);
    add("idle",       0, 0, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b000000, M);
    // dependency stall with writeback bypass
    add("dep_wr5",    0, 1, 3'b100, 5, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b100000, M);
    add("dep_stl1",   0, 1, 3'b010, 0, 5, 0, 4'b0000, 2'b00, 0, 0, 6'b010000, M);
    add("dep_stl2",   0, 1, 3'b010, 0, 5, 0, 4'b0000, 2'b00, 0, 0, 6'b010000, M);
    add("dep_bypass", 0, 1, 3'b010, 0, 5, 0, 4'b0000, 2'b00, 1, 5, 6'b100000, M);
    // x0 is never pending
    add("x0_wr",      0, 1, 3'b100, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b100000, M);
    add("x0_rd",      0, 1, 3'b010, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b100000, M);
    add("x0_wr_rd",   0, 1, 3'b110, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b100000, M);
    // branch, redirect
    add("br1_issue",  0, 1, 3'b000, 0, 0, 0, 4'b0100, 2'b00, 0, 0, 6'b100000, M);
    add("br1_w1",     0, 1, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b010000, M);
    add("br1_w2",     0, 1, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b010000, M);
    add("br1_w3",     0, 1, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b010000, M);
    add("br1_redir",  0, 1, 3'b000, 0, 0, 0, 4'b0000, 2'b11, 0, 0, 6'b001000, M);
    add("br1_after",  0, 1, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b100000, M);
    // branch, not taken
    add("br2_issue",  0, 1, 3'b000, 0, 0, 0, 4'b0100, 2'b00, 0, 0, 6'b100000, M);
    add("br2_w1",     0, 1, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b010000, M);
    add("br2_nored",  0, 1, 3'b000, 0, 0, 0, 4'b0000, 2'b10, 0, 0, 6'b000000, M);
    add("br2_after",  0, 1, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b100000, M);
    add("res_in_run", 0, 1, 3'b000, 0, 0, 0, 4'b0000, 2'b11, 0, 0, 6'b100000, M);
    // ecall: one-cycle trap with issue
    add("ecall",      0, 1, 3'b000, 0, 0, 0, 4'b0001, 2'b00, 0, 0, 6'b100100, M);
    add("ecall_next", 0, 1, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b100000, M);
    // WAW with same-cycle writeback: set wins
    add("waw_wr3",    0, 1, 3'b100, 3, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b100000, M);
    add("waw_coll",   0, 1, 3'b100, 3, 0, 0, 4'b0000, 2'b00, 1, 3, 6'b100000, M);
    add("waw_still",  0, 1, 3'b010, 0, 3, 0, 4'b0000, 2'b00, 0, 0, 6'b010000, M);
    add("waw_retire", 0, 0, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 1, 3, 6'b000000, M);
    add("waw_free",   0, 1, 3'b001, 0, 0, 3, 4'b0000, 2'b00, 0, 0, 6'b100000, M);
    // rd and rs2 hazards
    add("wr4",        0, 1, 3'b100, 4, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b100000, M);
    add("rd4_haz",    0, 1, 3'b100, 4, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b010000, M);
    add("rs2_4_haz",  0, 1, 3'b001, 0, 0, 4, 4'b0000, 2'b00, 1, 9, 6'b010000, M);
    add("ret4",       0, 0, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 1, 4, 6'b000000, M);
    // ebreak drain with x7, x9 pending
    add("wr7",        0, 1, 3'b100, 7, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b100000, M);
    add("wr9",        0, 1, 3'b100, 9, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b100000, M);
    add("ebreak",     0, 1, 3'b000, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 6'b010000, M);
    add("drain1",     0, 1, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b010000, M);
    add("drain_wb7",  0, 1, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 1, 7, 6'b010000, M);
    add("drain_wb9",  0, 1, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 1, 9, 6'b010000, M);
    add("halted1",    0, 0, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b010010, M);
    add("halted2",    0, 1, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b010010, M);
    add("halted_res", 0, 1, 3'b000, 0, 0, 0, 4'b0000, 2'b11, 0, 0, 6'b010010, M);
    add("halt_rst",   1, 0, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b000000, M);
    add("post_halt",  0, 1, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b100000, M);
    // ebreak with empty scoreboard
    add("ebrk_empty", 0, 1, 3'b000, 0, 0, 0, 4'b0010, 2'b00, 0, 0, 6'b010000, M);
    add("drain_emp",  0, 0, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b010000, M);
    add("halt_emp",   0, 0, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b010010, M);
    add("rst2",       1, 0, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b000000, M);
    // decode error lockup
    add("derr",       0, 1, 3'b000, 0, 0, 0, 4'b1000, 2'b00, 0, 0, 6'b000000, MI);
    add("err1",       0, 0, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b011001, M);
    add("err2",       0, 1, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b011001, M);
    add("err3",       0, 1, 3'b000, 0, 0, 0, 4'b0100, 2'b11, 0, 0, 6'b011001, M);
    add("err_rst",    1, 1, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b000000, M);
    add("post_err",   0, 1, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b100000, M);
    // decode error outranks a hazard
    add("wr6",        0, 1, 3'b100, 6, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b100000, M);
    add("derr_haz",   0, 1, 3'b010, 0, 6, 0, 4'b1010, 2'b00, 0, 0, 6'b000000, MI);
    add("err_haz",    0, 0, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b011001, M);
    add("rst3",       1, 0, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b000000, M);
    // reset mid WAIT_CTRL and scoreboard clear by reset
    add("br3_issue",  0, 1, 3'b000, 0, 0, 0, 4'b0100, 2'b00, 0, 0, 6'b100000, M);
    add("br3_w1",     0, 1, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b010000, M);
    add("br3_rst",    1, 1, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b000000, M);
    add("br3_run",    0, 1, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b100000, M);
    add("wr8",        0, 1, 3'b100, 8, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b100000, M);
    add("rst4",       1, 0, 3'b000, 0, 0, 0, 4'b0000, 2'b00, 0, 0, 6'b000000, M);
    add("rs1_8_free", 0, 1, 3'b010, 0, 8, 0, 4'b0000, 2'b00, 0, 0, 6'b100000, M);

    foreach (vq[i]) run_vec(vq[i]);

    // Long control-transfer wait with pending-write traffic in flight
    h = vq[0];
    h.rst = 0; h.idv = 1; h.en = 3'b100; h.rd = 5'd12; h.ctl = 4'b0100; h.ex = 2'b00;
    h.wbv = 0; h.wbrd = 0; h.mask = M;
    h.name = "long_br_issue"; h.exp = 6'b100000; run_vec(h);
    for (int k = 0; k < 6; k++) begin
      h.name = $sformatf("long_br_wait%0d", k);
      h.en = 3'b000; h.ctl = 4'b0000; h.exp = 6'b010000;
      run_vec(h);
    end
    h.name = "long_br_flush"; h.ex = 2'b11; h.exp = 6'b001000; run_vec(h);
    h.name = "long_br_dep";   h.ex = 2'b00; h.en = 3'b010; h.rs1 = 5'd12; h.exp = 6'b010000;
    run_vec(h);
    h.name = "long_br_byp";   h.wbv = 1; h.wbrd = 5'd12; h.exp = 6'b100000; run_vec(h);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
- Sequences the decode stage into execute. Consumes the per-instruction control bundle produced by the decoder.
- Decides each cycle whether the decoded instruction issues, stalls or is flushed.
- Tracks in-flight register writes in a 1-bit-per-register scoreboard.
- Serialises control transfers and runs the environment sequence: ecall trap, ebreak drain/halt, decode-error lockup.

Parameters:
RF_SIZE, 5, register index width; scoreboard has 2**RF_SIZE entries
CNT_WIDTH, 32, width of performance counters (PERF_CNT_EN only)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
id_valid_i  in  1  decode stage holds a valid instruction
rd_enable_i  in  1  instruction writes rd
rs1_enable_i  in  1  instruction reads rs1
rs2_enable_i  in  1  instruction reads rs2
rd_i  in  RF_SIZE  destination index
rs1_i  in  RF_SIZE  source 1 index
rs2_i  in  RF_SIZE  source 2 index
ctrl_xfer_i  in  1  branch, jal or jalr (OR of the decoder flags)
env_interrupt_i  in  2  bit0 ecall, bit1 ebreak
decode_error_i  in  1  illegal opcode
ex_resolve_i  in  1  EX resolved the outstanding control transfer this cycle
ex_redirect_i  in  1  with ex_resolve_i: PC redirected (taken / jump)
wb_valid_i  in  1  writeback retires a register write
wb_rd_i  in  RF_SIZE  writeback destination
issue_o  out  1  instruction enters EX this cycle
stall_o  out  1  hold PC and IF/ID register
flush_o  out  1  squash IF/ID contents
trap_o  out  1  one-cycle ecall pulse
halted_o  out  1  core stopped by ebreak
error_o  out  1  sticky decode-error lockup

Behaviour:
- Reset (sync, rst_i high at clk edge):
  - All scoreboard bits 0; state RUN.
  - All outputs 0.
  - Reset mid-sequence (any state) returns to RUN in one cycle.
- Hazard:
  - Instruction is blocked if any enabled source or enabled rd has its pending bit set.
  - Index 0 never counts as pending.
  - Writeback bypass: pending bit is treated as clear if wb_valid_i and wb_rd_i match that index in the same cycle.
- Scoreboard update, per cycle:
  - Clear bit wb_rd_i when wb_valid_i.
  - Set bit rd_i on issue when rd_enable_i and rd_i != 0.
  - If set and clear target the same index, set wins.
  - Writeback to an index that is not pending is ignored.
- States: RUN, WAIT_CTRL, DRAIN, HALT, ERR.
- RUN, id_valid_i high; priority is top to bottom:
  - decode_error_i: no issue, go to ERR.
  - ebreak: no issue, stall_o=1, go to DRAIN.
  - Hazard: stall_o=1, issue_o=0.
  - ecall: issue_o=1 and trap_o=1 in the same cycle.
  - ctrl_xfer_i: issue_o=1, go to WAIT_CTRL.
  - Otherwise: issue_o=1.
- RUN, id_valid_i low: all outputs 0.
- WAIT_CTRL:
  - stall_o=1, issue_o=0 until ex_resolve_i.
  - On resolve: flush_o=ex_redirect_i, stall_o=0 in that cycle, next state RUN.
  - The decode slot is not evaluated in the resolve cycle.
  - ex_resolve_i in any other state is ignored.
- DRAIN:
  - stall_o=1 until the scoreboard is all-zero, counting the current-cycle writeback clear.
  - Then go to HALT.
- HALT: halted_o=1, stall_o=1; exit only by reset.
- ERR: error_o=1, stall_o=1, flush_o=1 every cycle; exit only by reset.
- Latency:
  - Issue decision is combinational from inputs and current state.
  - State and scoreboard update at the clock edge.
  - A writer issued in cycle N blocks dependants from cycle N+1.
- issue_o and stall_o are never both 1.

Optional Feature:
- PERF_CNT_EN defined:
  - Adds outputs perf_issued_o and perf_stall_o, each CNT_WIDTH bits.
  - perf_issued_o counts issue_o cycles.
  - perf_stall_o counts cycles with stall_o && !halted_o && !error_o.
  - Both reset to 0 and wrap modulo 2**CNT_WIDTH.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Dependency stall: issue rd=5; next instruction rs1=5 -> stall_o=1 until wb_valid_i with wb_rd_i=5. Issue happens in that same wb cycle (bypass).
- x0 writes: issue rd=0, then rs1=0 -> both issue back-to-back, no stall, scoreboard stays 0.
- Branch: issue branch -> WAIT_CTRL, stall 3 cycles. ex_resolve_i=1 with ex_redirect_i=1 -> flush_o=1 one cycle, then RUN. Repeat with redirect=0 -> flush_o=0.
- ebreak drain: x7 and x9 pending, then ebreak -> stall_o until both retire -> halted_o=1 next cycle, stays 1. rst_i -> halted_o=0, state RUN.
- ecall and error: ecall -> issue_o=1 and trap_o=1 for exactly one cycle. decode_error_i -> error_o=1 sticky, flush_o=1, issue_o=0 until reset.
- WAW and collision: rd=3 pending; writer rd=3 arrives with wb_rd_i=3 same cycle -> issues, bit 3 remains set.
